// File: rtl/alu.sv
// alu: N-bit ripple-carry add/subtract unit with bus-gated result and registered carry/zero flags.
module alu #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         output_alu,
  input  logic         subtract_enable,
  input  logic [N-1:0] data_in_a,
  input  logic [N-1:0] data_in_b,
  input  logic         latch_flags,
  output logic [N-1:0] data_out,
  output logic         flag_carry,
  output logic         flag_zero
);
  logic [N-1:0] b_eff, sum;
  logic [N:0]   c;
  logic         carry_q, carry_d, zero_q, zero_d;
  assign b_eff = subtract_enable ? ~data_in_b : data_in_b;
  assign c[0]  = subtract_enable;
  genvar i;
  for (i = 0; i < N; i++) begin : g_fa
    assign sum[i]   = data_in_a[i] ^ b_eff[i] ^ c[i];
    assign c[i + 1] = (data_in_a[i] & b_eff[i]) | (c[i] & (data_in_a[i] ^ b_eff[i]));
  end
  // Idle bus drives zeros so it can be OR-muxed with other sources.
  assign data_out = output_alu ? sum : {N{1'b0}};
  always_comb begin
    carry_d = latch_flags ? c[N] : carry_q;
    zero_d  = latch_flags ? (sum == {N{1'b0}}) : zero_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      carry_q <= carry_d;
      zero_q  <= zero_d;
    end
  end
  assign flag_carry = carry_q;
  assign flag_zero  = zero_q;
endmodule

// File: tb/tb_alu.sv
// tb_alu: directed-vector bench for the alu add/subtract unit and its flags.
module tb_alu;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       output_alu = 1'b0;
  logic       subtract_enable = 1'b0;
  logic [7:0] data_in_a = 8'h00;
  logic [7:0] data_in_b = 8'h00;
  logic       latch_flags = 1'b0;
  logic [7:0] data_out;
  logic       flag_carry, flag_zero;
  int checks = 0;
  int failures = 0;

  alu #(.N(8)) dut (
    .clk(clk), .reset(reset), .output_alu(output_alu), .subtract_enable(subtract_enable),
    .data_in_a(data_in_a), .data_in_b(data_in_b), .latch_flags(latch_flags),
    .data_out(data_out), .flag_carry(flag_carry), .flag_zero(flag_zero)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic sub, input logic oe, input logic [7:0] a, input logic [7:0] b);
    subtract_enable = sub;
    output_alu = oe;
    data_in_a = a;
    data_in_b = b;
    #1;
  endtask

  task automatic pulse_latch();
    @(negedge clk);
    latch_flags = 1'b1;
    @(posedge clk);
    #1;
    latch_flags = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (flag_carry !== 1'b0 || flag_zero !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags got c=%b z=%b want c=0 z=0", flag_carry, flag_zero);
    end
    checks++;
    if (data_out !== 8'h00) begin
      failures++;
      $display("FAIL reset_data_out got %h want 00", data_out);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_add();
    drive(1'b0, 1'b1, 8'h0F, 8'hF0);
    checks++;
    if (data_out !== 8'hFF) begin
      failures++;
      $display("FAIL add_0F_F0 got %h want FF", data_out);
    end
    pulse_latch();
    checks++;
    if (flag_carry !== 1'b0 || flag_zero !== 1'b0) begin
      failures++;
      $display("FAIL add_0F_F0_flags got c=%b z=%b want c=0 z=0", flag_carry, flag_zero);
    end
    drive(1'b0, 1'b1, 8'h07, 8'hE0);
    checks++;
    if (data_out !== 8'hE7) begin
      failures++;
      $display("FAIL add_07_E0 got %h want E7", data_out);
    end
    drive(1'b0, 1'b1, 8'h0F, 8'h00);
    checks++;
    if (data_out !== 8'h0F) begin
      failures++;
      $display("FAIL add_0F_00 got %h want 0F", data_out);
    end
  endtask

  task automatic test_sub();
    drive(1'b1, 1'b1, 8'hFF, 8'h8F);
    checks++;
    if (data_out !== 8'h70) begin
      failures++;
      $display("FAIL sub_FF_8F got %h want 70", data_out);
    end
    pulse_latch();
    checks++;
    if (flag_carry !== 1'b1 || flag_zero !== 1'b0) begin
      failures++;
      $display("FAIL sub_FF_8F_flags got c=%b z=%b want c=1 z=0", flag_carry, flag_zero);
    end
    drive(1'b1, 1'b1, 8'hFF, 8'hF0);
    checks++;
    if (data_out !== 8'h0F) begin
      failures++;
      $display("FAIL sub_FF_F0 got %h want 0F", data_out);
    end
    drive(1'b1, 1'b1, 8'h5A, 8'h5A);
    pulse_latch();
    checks++;
    if (data_out !== 8'h00 || flag_carry !== 1'b1 || flag_zero !== 1'b1) begin
      failures++;
      $display("FAIL sub_equal got d=%h c=%b z=%b want d=00 c=1 z=1", data_out, flag_carry, flag_zero);
    end
  endtask

  task automatic test_wrap();
    drive(1'b0, 1'b1, 8'hFF, 8'h01);
    checks++;
    if (data_out !== 8'h00) begin
      failures++;
      $display("FAIL wrap_FF_01 got %h want 00", data_out);
    end
    pulse_latch();
    checks++;
    if (flag_carry !== 1'b1 || flag_zero !== 1'b1) begin
      failures++;
      $display("FAIL wrap_FF_01_flags got c=%b z=%b want c=1 z=1", flag_carry, flag_zero);
    end
    drive(1'b1, 1'b1, 8'h00, 8'h01);
    checks++;
    if (data_out !== 8'hFF) begin
      failures++;
      $display("FAIL borrow_00_01 got %h want FF", data_out);
    end
    pulse_latch();
    checks++;
    if (flag_carry !== 1'b0 || flag_zero !== 1'b0) begin
      failures++;
      $display("FAIL borrow_00_01_flags got c=%b z=%b want c=0 z=0", flag_carry, flag_zero);
    end
    drive(1'b0, 1'b1, 8'h80, 8'h80);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (flag_carry !== 1'b0 || flag_zero !== 1'b0) begin
      failures++;
      $display("FAIL flags_hold got c=%b z=%b want c=0 z=0", flag_carry, flag_zero);
    end
  endtask

  task automatic test_gating();
    drive(1'b0, 1'b0, 8'h12, 8'h34);
    checks++;
    if (data_out !== 8'h00) begin
      failures++;
      $display("FAIL gate_off got %h want 00", data_out);
    end
    output_alu = 1'b1;
    #0;
    #0;
    checks++;
    if (data_out !== 8'h46) begin
      failures++;
      $display("FAIL gate_on_same_step got %h want 46", data_out);
    end
    drive(1'b0, 1'b0, 8'hFF, 8'h01);
    pulse_latch();
    checks++;
    if (data_out !== 8'h00 || flag_carry !== 1'b1 || flag_zero !== 1'b1) begin
      failures++;
      $display("FAIL latch_while_gated got d=%h c=%b z=%b want d=00 c=1 z=1", data_out, flag_carry, flag_zero);
    end
  endtask

  task automatic test_async_reset();
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if (flag_carry !== 1'b0 || flag_zero !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got c=%b z=%b want c=0 z=0", flag_carry, flag_zero);
    end
    latch_flags = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (flag_carry !== 1'b0 || flag_zero !== 1'b0) begin
      failures++;
      $display("FAIL reset_beats_latch got c=%b z=%b want c=0 z=0", flag_carry, flag_zero);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    latch_flags = 1'b0;
    checks++;
    if (flag_carry !== 1'b1 || flag_zero !== 1'b1) begin
      failures++;
      $display("FAIL latch_after_reset got c=%b z=%b want c=1 z=1", flag_carry, flag_zero);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_wrap();
    test_gating();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
